// File: rtl/mul_div_unit_pkg.sv
// Shared types and constants for the iterative HI/LO multiply/divide unit.
package mul_div_unit_pkg;

  localparam int DATA_W = 32;
  localparam logic [5:0] MD_ITERS = 6'd32;
  // Cycles spent in FIX and DONE after the last iteration.
  localparam int MD_FIX_LAT = 2;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/md_sign_fix.sv
// Operand magnitude extraction at start and final sign/divide-by-zero correction.
module md_sign_fix
  import mul_div_unit_pkg::*;
(
  input  md_op_e              op,
  input  logic [DATA_W-1:0]   in1,
  input  logic [DATA_W-1:0]   in2,
  output logic [DATA_W-1:0]   mag1,
  output logic [DATA_W-1:0]   mag2,
  output logic                sgn1,
  output logic                sgn2,
  input  md_op_e              op_q,
  input  logic                sgn1_q,
  input  logic                sgn2_q,
  input  logic [DATA_W-1:0]   mag1_q,
  input  logic [DATA_W-1:0]   mag2_q,
  input  logic [2*DATA_W-1:0] work,
  output logic [DATA_W-1:0]   hi_res,
  output logic [DATA_W-1:0]   lo_res
);

  logic                       is_signed;
  logic signed [2*DATA_W-1:0] prod_s;
  logic signed [DATA_W-1:0]   quo_s;
  logic signed [DATA_W-1:0]   rem_s;

  assign is_signed = (op == MD_MULT) || (op == MD_DIV);
  assign sgn1 = is_signed & in1[DATA_W-1];
  assign sgn2 = is_signed & in2[DATA_W-1];
  assign mag1 = sgn1 ? (~in1 + 1'b1) : in1;
  assign mag2 = sgn2 ? (~in2 + 1'b1) : in2;

  always_comb begin
    prod_s = (sgn1_q ^ sgn2_q) ? -$signed(work) : $signed(work);
    quo_s  = (sgn1_q ^ sgn2_q) ? -$signed(work[DATA_W-1:0]) : $signed(work[DATA_W-1:0]);
    rem_s  = sgn1_q ? -$signed(work[2*DATA_W-1:DATA_W]) : $signed(work[2*DATA_W-1:DATA_W]);
    hi_res = prod_s[2*DATA_W-1:DATA_W];
    lo_res = prod_s[DATA_W-1:0];
    if (op_q == MD_DIV || op_q == MD_DIVU) begin
      if (mag2_q == '0) begin
        // Divide by zero: all-ones quotient, dividend restored with its sign.
        lo_res = '1;
        hi_res = sgn1_q ? (~mag1_q + 1'b1) : mag1_q;
      end else begin
        lo_res = quo_s;
        hi_res = rem_s;
      end
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32-cycle multiply/divide unit driving architectural HI/LO registers.
module mul_div_unit
  import mul_div_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic              flush,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              done
);

  md_state_e           state_q, state_d;
  md_op_e              op_q;
  logic                sgn1_q, sgn2_q;
  logic [DATA_W-1:0]   mag1_q, mag2_q;
  logic [2*DATA_W-1:0] work_q;
  logic [5:0]          cnt_q;

  logic [DATA_W-1:0]   mag1, mag2, hi_res, lo_res;
  logic                sgn1, sgn2, go;
  logic [DATA_W:0]     mul_sum, div_cand, div_diff;
  logic                div_ge;
  logic [2*DATA_W-1:0] work_mul, work_div;

  md_sign_fix u_sign_fix (
    .op     (md_op_e'(op)),
    .in1    (in1),
    .in2    (in2),
    .mag1   (mag1),
    .mag2   (mag2),
    .sgn1   (sgn1),
    .sgn2   (sgn2),
    .op_q   (op_q),
    .sgn1_q (sgn1_q),
    .sgn2_q (sgn2_q),
    .mag1_q (mag1_q),
    .mag2_q (mag2_q),
    .work   (work_q),
    .hi_res (hi_res),
    .lo_res (lo_res)
  );

  assign go   = (state_q == ST_IDLE) && start && !flush;
  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

  // One iteration: work = {acc, multiplier} for multiply, {remainder, quotient} for divide.
  always_comb begin
    mul_sum  = {1'b0, work_q[2*DATA_W-1:DATA_W]} + (work_q[0] ? {1'b0, mag2_q} : '0);
    work_mul = {mul_sum, work_q[DATA_W-1:1]};
    div_cand = {work_q[2*DATA_W-1:DATA_W], work_q[DATA_W-1]};
    div_ge   = (div_cand >= {1'b0, mag2_q});
    div_diff = div_cand - {1'b0, mag2_q};
    work_div = {(div_ge ? div_diff[DATA_W-1:0] : div_cand[DATA_W-1:0]),
                work_q[DATA_W-2:0], div_ge};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (go) state_d = ST_CALC;
      ST_CALC: begin
        if (flush)                           state_d = ST_IDLE;
        else if (cnt_q == MD_ITERS - 6'd1)   state_d = ST_FIX;
      end
      ST_FIX:  state_d = flush ? ST_IDLE : ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= MD_MULT;
      sgn1_q <= 1'b0;
      sgn2_q <= 1'b0;
      mag1_q <= '0;
      mag2_q <= '0;
      work_q <= '0;
      cnt_q  <= '0;
    end else if (go) begin
      op_q   <= md_op_e'(op);
      sgn1_q <= sgn1;
      sgn2_q <= sgn2;
      mag1_q <= mag1;
      mag2_q <= mag2;
      work_q <= {{DATA_W{1'b0}}, mag1};
      cnt_q  <= '0;
    end else if (state_q == ST_CALC) begin
      work_q <= (op_q == MD_MULT || op_q == MD_MULTU) ? work_mul : work_div;
      cnt_q  <= cnt_q + 6'd1;
    end
  end

  // Result commit on FIX->DONE; direct writes only while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (state_q == ST_FIX && !flush) begin
      hi <= hi_res;
      lo <= lo_res;
    end else if (!busy) begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port start, input, 1, request a new operation, sampled only in IDLE.
REQ-004 SHALL have port op, input, 2, operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
REQ-005 SHALL have port in1, input, 32, multiplicand or dividend.
REQ-006 SHALL have port in2, input, 32, multiplier or divisor.
REQ-007 SHALL have port flush, input, 1, abort the operation in flight (pipeline exception).
REQ-008 SHALL have ports hi_we and lo_we, input, 1 each, direct HI/LO writes (MTHI/MTLO).
REQ-009 SHALL have port wdata, input, 32, data for hi_we/lo_we.
REQ-010 SHALL have ports hi and lo, output, 32 each, architectural HI/LO registers.
REQ-011 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-012 SHALL have port done, output, 1, one-cycle pulse when HI/LO take a new result.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-014 IDLE with start=1 SHALL latch op, |in1|, |in2| and result signs, clear the step counter, and enter CALC; the operands are used in magnitude form for signed ops.
REQ-015 CALC SHALL perform exactly 32 iterations: radix-2 shift-add for multiply, restoring shift-subtract for divide, using a 64-bit working register.
REQ-016 After iteration 32, CALC SHALL go to FIX; FIX SHALL apply sign correction and go to DONE.
REQ-017 Signed multiply: negate the 64-bit product if the operand signs differ.
REQ-018 Signed divide: quotient negated if the operand signs differ; remainder takes the sign of the dividend.
REQ-019 hi/lo SHALL update on entry to DONE, with done=1 for that single cycle; DONE SHALL return to IDLE next cycle.
REQ-020 Latency SHALL be fixed: start sampled in cycle 0 gives done=1 and new hi/lo visible in cycle 34.
REQ-021 Multiply results SHALL go to hi = product[63:32] and lo = product[31:0].
REQ-022 Divide results SHALL go to lo = quotient and hi = remainder.
REQ-023 Divide by zero, all ops, SHALL give lo = 32'hFFFF_FFFF and hi = in1, at the same latency.
REQ-024 DIV of 32'h8000_0000 by 32'hFFFF_FFFF SHALL give lo = 32'h8000_0000 and hi = 0.
REQ-025 start while busy SHALL be ignored, with no queuing.
REQ-026 flush in any non-IDLE state SHALL return the FSM to IDLE next cycle, leave hi/lo unchanged and suppress done.
REQ-027 flush and start together in IDLE: flush SHALL win and no operation starts.
REQ-028 hi_we/lo_we SHALL write wdata only when busy=0; when busy=1 they are ignored.
REQ-029 hi_we/lo_we together with start in IDLE: the write SHALL take effect and the operation SHALL also start; its result later overwrites the written value.
REQ-030 in1/in2/op SHALL be don't-care after the start cycle.

Reset
REQ-031 rst SHALL asynchronously force state IDLE, hi = 0, lo = 0, busy = 0, done = 0, counter = 0, working register = 0.
REQ-032 rst during CALC/FIX/DONE SHALL abandon the operation; no done pulse SHALL follow the release of reset.

Structure
REQ-033 The shared package SHALL hold: the op enum (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU), the FSM state enum, the 6-bit iteration-count constant 32 and the FIX/DONE latency constant.
REQ-034 One combinational sub-module, md_sign_fix, SHALL compute operand magnitudes and final sign correction; the FSM and datapath stay in mul_div_unit.

Verification
REQ-035 MULT in1=32'hFFFF_FFFD (-3), in2=5 -> cycle 34 done=1, hi=32'hFFFF_FFFF, lo=32'hFFFF_FFF1.
REQ-036 DIVU 100/7 -> lo=14, hi=2; DIV -7/2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF.
REQ-037 DIVU in1=32'h1234, in2=0 -> lo=32'hFFFF_FFFF, hi=32'h1234; DIV 32'h8000_0000/-1 -> lo=32'h8000_0000, hi=0.
REQ-038 MULTU 32'hFFFF_FFFF*32'hFFFF_FFFF, with a second start at cycle 10 -> second start ignored, hi=32'hFFFF_FFFE, lo=1, single done pulse.
REQ-039 Preload hi=32'hAAAA_AAAA via hi_we, start DIV, assert flush at cycle 15 -> busy=0 at cycle 16, no done, hi unchanged; hi_we during busy ignored.
REQ-040 Assert rst asynchronously mid-CALC -> hi=lo=0 and busy=0 immediately; no done after release.
